// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: passive monitor for a multiplexed 4-digit seven-segment bus.
// Samples anode/cathode pins, waits for each digit slot to settle, decodes the
// pattern back to BCD and publishes each complete scan as one atomic frame.
module seg_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic        MegaClk,
    input  logic        reset,
    input  logic [3:0]  trigger,
    input  logic [7:0]  segBits,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  invalid,
    output logic        frame_valid,
    output logic [15:0] frame_cnt,
    output logic        stalled,
    output logic        multi_err
);
    localparam int SW = $clog2(SETTLE);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
    localparam logic [IW-1:0] IDLE_PRE = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HELD} state_t;

    state_t          state, state_nxt;
    logic [3:0]      s_trig;
    logic [7:0]      s_seg;
    logic [SW-1:0]   stab_cnt;
    logic [IW-1:0]   idle_cnt;
    logic [3:0]      seen;
    logic [3:0][3:0] stg_dig;
    logic [3:0]      stg_blank, stg_inv;

    logic            same, trig_one, in_one, trig_multi, capture;
    logic [1:0]      cap_idx;
    logic [3:0]      dec_dig;
    logic            dec_blank, dec_inv;

    // Incoming pins match the held sample: the slot is still stable this cycle.
    assign same       = ({trigger, segBits} == {s_trig, s_seg});
    assign trig_one   = ($countones(~s_trig) == 1);
    assign in_one     = ($countones(~trigger) == 1);
    assign trig_multi = ($countones(~s_trig) >= 2);
    // Capture needs the counter saturated and one more identical sample, so a
    // slot must dwell SETTLE+1 cycles before it is taken.
    assign capture    = (state == S_SETTLE) && same && trig_one && (stab_cnt == STAB_MAX);

    // Position of the single low anode in the held sample.
    always_comb begin
        cap_idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!s_trig[i]) cap_idx = 2'(i);
    end

    // Segment pattern to BCD; dp is ignored, all-dark is blank, others invalid.
    always_comb begin
        dec_dig   = 4'hF;
        dec_blank = 1'b0;
        dec_inv   = 1'b0;
        case (s_seg[6:0])
            7'h40: dec_dig = 4'd0;
            7'h79: dec_dig = 4'd1;
            7'h24: dec_dig = 4'd2;
            7'h30: dec_dig = 4'd3;
            7'h19: dec_dig = 4'd4;
            7'h12: dec_dig = 4'd5;
            7'h02: dec_dig = 4'd6;
            7'h78: dec_dig = 4'd7;
            7'h00: dec_dig = 4'd8;
            7'h10: dec_dig = 4'd9;
            7'h7F: begin dec_dig = 4'd0; dec_blank = 1'b1; end
            default: dec_inv = 1'b1;
        endcase
    end

    // Slot FSM: wait for a single anode, settle, then hold until the bus moves.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:   if (trig_one) state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (capture)        state_nxt = S_HELD;
                else if (!same)     state_nxt = in_one ? S_SETTLE : S_WAIT;
                else if (!trig_one) state_nxt = S_WAIT;
            end
            S_HELD:   if (!same) state_nxt = in_one ? S_SETTLE : S_WAIT;
            default:  state_nxt = S_WAIT;
        endcase
    end

    // State register.
    always_ff @(posedge MegaClk) begin
        if (reset) state <= S_WAIT;
        else       state <= state_nxt;
    end

    // Input sampling, stability counting, staging, publish and idle tracking.
    always_ff @(posedge MegaClk) begin
        if (reset) begin
            s_trig      <= 4'hF;
            s_seg       <= 8'hFF;
            stab_cnt    <= '0;
            idle_cnt    <= '0;
            seen        <= 4'h0;
            stg_dig     <= '0;
            stg_blank   <= 4'h0;
            stg_inv     <= 4'h0;
            digits      <= 16'h0;
            blank       <= 4'hF;
            invalid     <= 4'h0;
            frame_valid <= 1'b0;
            frame_cnt   <= 16'h0;
            stalled     <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            s_trig <= trigger;
            s_seg  <= segBits;

            if (!same)                  stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 1'b1;

            if (trig_multi) multi_err <= 1'b1;

            frame_valid <= 1'b0;
            // Publish one cycle after the mask completes; a capture in this
            // same cycle survives because its bit write follows the clear.
            if (seen == 4'hF) begin
                digits      <= stg_dig;
                blank       <= stg_blank;
                invalid     <= stg_inv;
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 16'd1;
                seen        <= 4'h0;
            end

            if (capture) begin
                seen[cap_idx]      <= 1'b1;
                stg_dig[cap_idx]   <= dec_dig;
                stg_blank[cap_idx] <= dec_blank;
                stg_inv[cap_idx]   <= dec_inv;
                idle_cnt           <= '0;
                stalled            <= 1'b0;
            end else if (idle_cnt == IDLE_PRE) begin
                idle_cnt <= IDLE_MAX;
                stalled  <= 1'b1;
                seen     <= 4'h0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with a short stall timeout.
module tb_seg_scan_decoder;
    localparam int TO = 64;
    // Active-low cathode bytes with dp dark.
    localparam logic [7:0] P0 = 8'hC0, P1 = 8'hF9, P2 = 8'hA4, P3 = 8'hB0, P4 = 8'h99;
    localparam logic [7:0] P5 = 8'h92, P6 = 8'h82, P7 = 8'hF8, P8 = 8'h80, P9 = 8'h90;
    localparam logic [7:0] PB = 8'hFF, PX = 8'hFE;

    logic        MegaClk = 1'b0;
    logic        reset;
    logic [3:0]  trigger;
    logic [7:0]  segBits;
    logic [15:0] digits;
    logic [3:0]  blank, invalid;
    logic        frame_valid;
    logic [15:0] frame_cnt;
    logic        stalled, multi_err;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int fv0;

    seg_scan_decoder #(.SETTLE(4), .TIMEOUT(TO)) dut (
        .MegaClk(MegaClk), .reset(reset), .trigger(trigger), .segBits(segBits),
        .digits(digits), .blank(blank), .invalid(invalid), .frame_valid(frame_valid),
        .frame_cnt(frame_cnt), .stalled(stalled), .multi_err(multi_err)
    );

    always #5 MegaClk = ~MegaClk;

    always @(negedge MegaClk) if (frame_valid === 1'b1) fv_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // All drive tasks start and end on a falling edge.
    task automatic slot(input int pos, input logic [7:0] seg, input int dwell);
        trigger = ~(4'(1) << pos);
        segBits = seg;
        repeat (dwell) @(negedge MegaClk);
    endtask

    task automatic gap(input int n);
        trigger = 4'hF;
        segBits = 8'hFF;
        repeat (n) @(negedge MegaClk);
    endtask

    task automatic scan(input logic [7:0] a, b, c, d, input int dwell);
        slot(0, a, dwell); slot(1, b, dwell); slot(2, c, dwell); slot(3, d, dwell);
        gap(4);
    endtask

    task automatic test_reset;
        reset = 1'b1; trigger = 4'hF; segBits = 8'hFF;
        repeat (3) @(negedge MegaClk);
        reset = 1'b0;
        @(negedge MegaClk);
        checks++;
        if ({digits, blank, invalid, frame_valid, frame_cnt, stalled, multi_err} !==
            {16'h0, 4'hF, 4'h0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got d=%h b=%h i=%h fv=%b fc=%h st=%b me=%b", digits, blank,
                     invalid, frame_valid, frame_cnt, stalled, multi_err);
        end
    endtask

    task automatic test_basic_frame;
        fv0 = fv_cnt;
        // pos2 carries a lit dp, which must not affect decoding
        scan(P1, P2, 8'h30, P4, 16);
        checks++;
        if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL basic_fv: got %0d pulses, exp 1", fv_cnt - fv0); end
        checks++;
        if ({digits, blank, invalid, frame_cnt} !== {16'h4321, 4'h0, 4'h0, 16'd1}) begin
            errors++;
            $display("FAIL basic_frame: got d=%h b=%h i=%h fc=%0d exp 4321/0/0/1", digits, blank, invalid, frame_cnt);
        end
    endtask

    task automatic test_min_dwell;
        fv0 = fv_cnt;
        scan(P5, P6, P7, P8, 4);
        checks++;
        if (fv_cnt - fv0 !== 0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL dwell4: got %0d pulses fc=%0d, exp 0 pulses fc=1", fv_cnt - fv0, frame_cnt);
        end
        scan(P5, P6, P7, P8, 5);
        checks++;
        if (fv_cnt - fv0 !== 1 || digits !== 16'h8765 || frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL dwell5: got %0d pulses d=%h fc=%0d, exp 1 8765 2", fv_cnt - fv0, digits, frame_cnt);
        end
    endtask

    task automatic test_blank_invalid;
        scan(P5, P9, PB, PB, 16);
        checks++;
        if ({digits, blank, invalid} !== {16'h0095, 4'b1100, 4'b0000}) begin
            errors++;
            $display("FAIL blank: got d=%h b=%b i=%b exp 0095/1100/0000", digits, blank, invalid);
        end
        scan(P0, PX, P8, P7, 16);
        checks++;
        if ({digits, blank, invalid, frame_cnt} !== {16'h78F0, 4'b0000, 4'b0010, 16'd4}) begin
            errors++;
            $display("FAIL invalid: got d=%h b=%b i=%b fc=%0d exp 78F0/0000/0010/4", digits, blank, invalid, frame_cnt);
        end
    endtask

    task automatic test_multi_err;
        checks++;
        if (multi_err !== 1'b0) begin errors++; $display("FAIL multi_pre: got %b exp 0", multi_err); end
        fv0 = fv_cnt;
        slot(0, P2, 16); slot(1, P3, 16);
        trigger = 4'b1100; segBits = P9;
        repeat (10) @(negedge MegaClk);
        slot(2, P4, 16); slot(3, P5, 16); gap(4);
        checks++;
        if (multi_err !== 1'b1) begin errors++; $display("FAIL multi_set: got %b exp 1", multi_err); end
        checks++;
        if (fv_cnt - fv0 !== 1 || digits !== 16'h5432 || frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL multi_frame: got %0d pulses d=%h fc=%0d exp 1 5432 5", fv_cnt - fv0, digits, frame_cnt);
        end
    endtask

    task automatic test_back_to_back;
        // positions arrive out of order: 3,1,0,2
        slot(3, P4, 8); slot(1, P2, 8); slot(0, P1, 8); slot(2, P3, 8); gap(4);
        checks++;
        if (digits !== 16'h4321 || frame_cnt !== 16'd6 || multi_err !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: got d=%h fc=%0d me=%b exp 4321 6 1", digits, frame_cnt, multi_err);
        end
    endtask

    task automatic test_stall;
        fv0 = fv_cnt;
        slot(0, P1, 16); slot(1, P1, 16);
        gap(40);
        checks++;
        if (stalled !== 1'b0) begin errors++; $display("FAIL stall_early: got %b exp 0", stalled); end
        gap(30);
        checks++;
        if (stalled !== 1'b1 || digits !== 16'h4321 || frame_cnt !== 16'd6) begin
            errors++;
            $display("FAIL stall_set: got st=%b d=%h fc=%0d exp 1 4321 6", stalled, digits, frame_cnt);
        end
        slot(2, P8, 16); slot(3, P9, 16); gap(4);
        checks++;
        if (stalled !== 1'b0 || fv_cnt - fv0 !== 0) begin
            errors++;
            $display("FAIL stall_clear: got st=%b pulses=%0d exp 0 0", stalled, fv_cnt - fv0);
        end
        slot(0, P6, 16); slot(1, P7, 16); gap(4);
        checks++;
        if (fv_cnt - fv0 !== 1 || digits !== 16'h9876 || frame_cnt !== 16'd7) begin
            errors++;
            $display("FAIL stall_frame: got %0d pulses d=%h fc=%0d exp 1 9876 7", fv_cnt - fv0, digits, frame_cnt);
        end
    endtask

    task automatic test_mid_reset;
        slot(0, P2, 16); slot(1, P2, 16); slot(2, P2, 16);
        trigger = 4'hF; segBits = 8'hFF; reset = 1'b1;
        repeat (2) @(negedge MegaClk);
        checks++;
        if ({digits, blank, invalid, frame_cnt, stalled, multi_err} !==
            {16'h0, 4'hF, 4'h0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got d=%h b=%h i=%h fc=%0d st=%b me=%b", digits, blank, invalid,
                     frame_cnt, stalled, multi_err);
        end
        reset = 1'b0;
        fv0 = fv_cnt;
        slot(3, P5, 16); gap(4);
        checks++;
        if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL partial_discard: got %0d pulses exp 0", fv_cnt - fv0); end
        slot(0, P6, 16); slot(1, P7, 16); slot(2, P8, 16); gap(4);
        checks++;
        if (digits !== 16'h5876 || frame_cnt !== 16'd1 || blank !== 4'h0) begin
            errors++;
            $display("FAIL post_reset_frame: got d=%h fc=%0d b=%h exp 5876 1 0", digits, frame_cnt, blank);
        end
    endtask

    initial begin
        reset = 1'b1; trigger = 4'hF; segBits = 8'hFF;
        @(negedge MegaClk);
        test_reset;
        test_basic_frame;
        test_min_dwell;
        test_blank_invalid;
        test_multi_err;
        test_back_to_back;
        test_stall;
        test_mid_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
